side_vram_cpu_if: RTL and testbench

SIDE_VRAM_CPU_IF -- requirements
Module: side_vram_cpu_if

---
 rtl/side_vram_pkg.sv | 28 ++
 rtl/side_vram_cpu_if.sv | 117 +++++++++++
 tb/tb_side_vram_cpu_if.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/side_vram_pkg.sv
// rtl/side_vram_pkg.sv - shared types and constants for the side-VRAM CPU interface
package side_vram_pkg;

    // Access sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // Default phase lengths in clock cycles (legal range 1..15 each)
    localparam int DEF_SETUP_CYC  = 1;
    localparam int DEF_STROBE_CYC = 2;

    // Levels driven onto the side bus when no access is in progress
    localparam logic [7:0] BUS_IDLE_DATA = 8'hFF;
    localparam logic       STROBE_OFF    = 1'b1;
    localparam logic       DIR_READ      = 1'b0;
    localparam logic       DIR_WRITE     = 1'b1;

    // Counter preload: a phase of n cycles counts n-1 down to 0
    function automatic logic [3:0] cyc_load(input int n);
        return 4'(n - 1);
    endfunction

endpackage

// File: rtl/side_vram_cpu_if.sv
// rtl/side_vram_cpu_if.sv - CPU to side-VRAM SRAM access sequencer
module side_vram_cpu_if
    import side_vram_pkg::*;
#(
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC
) (
    input  logic        clk,
    input  logic        VIDEO_RST,
    input  logic        cpu_cs,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [10:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_wait,
    output logic [10:0] VA,
    output logic [7:0]  VD_out,
    input  logic [7:0]  VD_in,
    output logic        SIDE_VRAM_CSn,
    output logic        VDG,
    output logic        VRD,
    output logic        VOE,
    output logic        VWE
);

    localparam logic [3:0] SETUP_LOAD  = cyc_load(SETUP_CYC);
    localparam logic [3:0] STROBE_LOAD = cyc_load(STROBE_CYC);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [10:0] r_addr;
    logic [7:0]  r_data;
    logic        r_dir;
    logic [7:0]  r_dout;

    logic        w_req;
    logic        w_active;
    logic        w_is_write;

    // A write wins when both rd and wr are asserted together
    assign w_req      = cpu_cs & (cpu_rd | cpu_wr);
    assign w_is_write = cpu_wr;

    // Stall the CPU until the access has reached RELEASE
    assign cpu_wait = w_req & (r_state != ST_RELEASE);

    // Sequencer: latches the request once, walks the phases, captures read data
    always_ff @(posedge clk or posedge VIDEO_RST) begin
        if (VIDEO_RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 11'd0;
            r_data  <= BUS_IDLE_DATA;
            r_dir   <= DIR_READ;
            r_dout  <= BUS_IDLE_DATA;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_addr  <= cpu_addr;
                        r_data  <= cpu_din;
                        r_dir   <= w_is_write ? DIR_WRITE : DIR_READ;
                        r_cnt   <= SETUP_LOAD;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == 4'd0) begin
                        r_cnt   <= STROBE_LOAD;
                        r_state <= ST_STROBE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_STROBE: begin
                    if (r_cnt == 4'd0) begin
                        if (r_dir == DIR_READ) begin
                            r_dout <= VD_in;
                        end
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    r_state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // A held request parks here so it can never start a second access
                    if (!w_req) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus strobes are decoded from state only, so async reset drops them at once
    always_comb begin
        w_active      = (r_state == ST_SETUP) || (r_state == ST_STROBE);
        SIDE_VRAM_CSn = w_active ? 1'b0 : STROBE_OFF;
        VDG           = w_active ? 1'b0 : STROBE_OFF;
        VRD           = w_active ? r_dir : DIR_READ;
        VOE           = (w_active && (r_dir == DIR_READ)) ? 1'b0 : STROBE_OFF;
        // Write pulse only in the first strobe cycle, leaving data hold time after it
        VWE           = ((r_state == ST_STROBE) && (r_dir == DIR_WRITE) && (r_cnt == STROBE_LOAD))
                        ? 1'b0 : STROBE_OFF;
        VD_out        = (w_active && (r_dir == DIR_WRITE)) ? r_data : BUS_IDLE_DATA;
        VA            = r_addr;
        cpu_dout      = r_dout;
    end

endmodule

// File: tb/tb_side_vram_cpu_if.sv
// tb/tb_side_vram_cpu_if.sv - self-checking bench for side_vram_cpu_if
module tb_side_vram_cpu_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs, rd, wr;
    logic [10:0] addr;
    logic [7:0]  din;
    logic [7:0]  cpu_dout, VD_out, VD_in;
    logic        cpu_wait, CSn, VDG, VRD, VOE, VWE;
    logic [10:0] VA;

    logic        cs2, rd2, wr2;
    logic [7:0]  cpu_dout2, VD_out2, VD_in2;
    logic        cpu_wait2, CSn2, VDG2, VRD2, VOE2, VWE2;
    logic [10:0] VA2;

    always #5 clk = ~clk;

    side_vram_cpu_if dut (
        .clk(clk), .VIDEO_RST(rst), .cpu_cs(cs), .cpu_rd(rd), .cpu_wr(wr),
        .cpu_addr(addr), .cpu_din(din), .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
        .VA(VA), .VD_out(VD_out), .VD_in(VD_in), .SIDE_VRAM_CSn(CSn),
        .VDG(VDG), .VRD(VRD), .VOE(VOE), .VWE(VWE)
    );

    side_vram_cpu_if #(.SETUP_CYC(3), .STROBE_CYC(1)) dut2 (
        .clk(clk), .VIDEO_RST(rst), .cpu_cs(cs2), .cpu_rd(rd2), .cpu_wr(wr2),
        .cpu_addr(addr), .cpu_din(din), .cpu_dout(cpu_dout2), .cpu_wait(cpu_wait2),
        .VA(VA2), .VD_out(VD_out2), .VD_in(VD_in2), .SIDE_VRAM_CSn(CSn2),
        .VDG(VDG2), .VRD(VRD2), .VOE(VOE2), .VWE(VWE2)
    );

    // SRAM model: write at the edge ending a VWE-low cycle, read while OE low
    logic [7:0] mem [0:2047];
    initial for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    always @(posedge clk) if (!CSn && !VWE) mem[VA] <= VD_out;
    assign VD_in  = (!CSn && !VOE) ? mem[VA] : 8'hFF;
    assign VD_in2 = (!CSn2 && !VOE2) ? 8'hC3 : 8'hFF;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [10:0] a;
        logic [7:0]  d;
        bit          scr;
        logic [7:0]  exp_dout;
    } vec_t;

    logic [7:0] sb_q[$];
    logic [5:0] m_csn, m_vwe, m_voe, m_wait;
    int         vd_bad, vrd_bad, va_bad;

    // One access: drive before edge 0, sample cycles 1..6 at the falling edge
    task automatic access(input vec_t v, input int drop_at, input bit use_sb);
        logic       prev_wait;
        logic [7:0] exp_vd;
        logic       exp_vrd;
        @(negedge clk);
        cs = 1'b1; rd = v.rd; wr = v.wr; addr = v.a; din = v.d;
        if (use_sb) sb_q.push_back(v.exp_dout);
        #1 prev_wait = cpu_wait;
        m_csn = '0; m_vwe = '0; m_voe = '0; m_wait = '0;
        vd_bad = 0; vrd_bad = 0; va_bad = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (k == 1 && v.scr) begin addr = ~v.a; din = ~v.d; end
            if (k == drop_at) begin cs = 1'b0; rd = 1'b0; wr = 1'b0; end
            @(negedge clk);
            m_csn[k-1]  = ~CSn;
            m_vwe[k-1]  = ~VWE;
            m_voe[k-1]  = ~VOE;
            m_wait[k-1] = cpu_wait;
            exp_vd  = (v.wr && k <= 3) ? v.d : 8'hFF;
            exp_vrd = (v.wr && k <= 3);
            if (VD_out !== exp_vd) vd_bad++;
            if (VRD !== exp_vrd) vrd_bad++;
            if (k <= 3 && VA !== v.a) va_bad++;
            if (cs && prev_wait && !cpu_wait) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_pop: got empty queue expected a pending read result");
                end else begin
                    check("sb_dout", cpu_dout, sb_q.pop_front());
                end
            end
            prev_wait = cpu_wait;
        end
    endtask

    task automatic release_req();
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    vec_t vecs[10];
    vec_t v;
    int   csn_cnt;

    initial begin
        vecs[0] = '{rd:0, wr:1, a:11'h155, d:8'hA5, scr:0, exp_dout:8'hFF};
        vecs[1] = '{rd:1, wr:0, a:11'h155, d:8'h00, scr:0, exp_dout:8'hA5};
        vecs[2] = '{rd:1, wr:1, a:11'h7FF, d:8'h3C, scr:0, exp_dout:8'hA5};
        vecs[3] = '{rd:1, wr:0, a:11'h7FF, d:8'h00, scr:0, exp_dout:8'h3C};
        vecs[4] = '{rd:0, wr:1, a:11'h000, d:8'h5A, scr:0, exp_dout:8'h3C};
        vecs[5] = '{rd:1, wr:0, a:11'h000, d:8'h00, scr:0, exp_dout:8'h5A};
        vecs[6] = '{rd:1, wr:0, a:11'h155, d:8'h00, scr:1, exp_dout:8'hA5};
        vecs[7] = '{rd:0, wr:1, a:11'h2AA, d:8'h77, scr:1, exp_dout:8'hA5};
        vecs[8] = '{rd:1, wr:0, a:11'h2AA, d:8'h00, scr:0, exp_dout:8'h77};
        vecs[9] = '{rd:1, wr:0, a:11'h123, d:8'h00, scr:0, exp_dout:8'h00};

        rst = 1'b1; cs = 0; rd = 0; wr = 0; cs2 = 0; rd2 = 0; wr2 = 0;
        addr = 11'h0; din = 8'h0;
        @(negedge clk); @(negedge clk);
        check("rst_csn", CSn, 1'b1);
        check("rst_vdg", VDG, 1'b1);
        check("rst_voe", VOE, 1'b1);
        check("rst_vwe", VWE, 1'b1);
        check("rst_vrd", VRD, 1'b0);
        check("rst_va", VA, 11'h0);
        check("rst_vd_out", VD_out, 8'hFF);
        check("rst_dout", cpu_dout, 8'hFF);
        check("rst_wait_idle", cpu_wait, 1'b0);
        cs = 1; rd = 1; #1;
        check("rst_wait_req", cpu_wait, 1'b1);
        cs = 0; rd = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven accesses with default timing
        for (int i = 0; i < 10; i++) begin
            access(vecs[i], 0, 1'b1);
            check($sformatf("v%0d_csn", i), m_csn, 6'b000111);
            check($sformatf("v%0d_vwe", i), m_vwe, vecs[i].wr ? 6'b000010 : 6'b000000);
            check($sformatf("v%0d_voe", i), m_voe, vecs[i].wr ? 6'b000000 : 6'b000111);
            check($sformatf("v%0d_wait", i), m_wait, 6'b001111);
            check($sformatf("v%0d_vd_bad", i), vd_bad, 0);
            check($sformatf("v%0d_vrd_bad", i), vrd_bad, 0);
            check($sformatf("v%0d_va_bad", i), va_bad, 0);
            release_req();
        end
        check("mem_155", mem[11'h155], 8'hA5);
        check("mem_7ff", mem[11'h7FF], 8'h3C);
        check("mem_2aa", mem[11'h2AA], 8'h77);

        // Held request: one access only, new access after low-then-high
        v = '{rd:0, wr:1, a:11'h3F0, d:8'h11, scr:0, exp_dout:8'h00};
        access(v, 0, 1'b1);
        check("hold_first_csn", m_csn, 6'b000111);
        csn_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!CSn) csn_cnt++;
            if (cpu_wait) csn_cnt += 100;
        end
        check("hold_no_second", csn_cnt, 0);
        cs = 0; wr = 0;
        @(negedge clk);
        check("hold_gap_csn", CSn, 1'b1);
        v = '{rd:1, wr:0, a:11'h3F0, d:8'h00, scr:0, exp_dout:8'h11};
        access(v, 0, 1'b1);
        check("hold_second_csn", m_csn, 6'b000111);
        release_req();

        // Request dropped during SETUP still completes, RELEASE exits at once
        v = '{rd:0, wr:1, a:11'h0AA, d:8'h99, scr:0, exp_dout:8'h00};
        access(v, 1, 1'b0);
        check("drop_csn", m_csn, 6'b000111);
        check("drop_vwe", m_vwe, 6'b000010);
        check("drop_wait", m_wait, 6'b000000);
        check("drop_vd_bad", vd_bad, 0);
        cs = 1; rd = 1; #1;
        check("drop_back_idle", cpu_wait, 1'b1);
        cs = 0; rd = 0;
        check("drop_mem", mem[11'h0AA], 8'h99);
        @(negedge clk);

        // Reset asserted in the VWE cycle of a write
        @(negedge clk);
        cs = 1; wr = 1; addr = 11'h100; din = 8'hEE;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("rstw_vwe_before", VWE, 1'b0);
        rst = 1'b1;
        #1;
        check("rstw_vwe", VWE, 1'b1);
        check("rstw_csn", CSn, 1'b1);
        check("rstw_vdg", VDG, 1'b1);
        check("rstw_vd_out", VD_out, 8'hFF);
        cs = 0; wr = 0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstw_mem", mem[11'h100], 8'h00);
        check("rstw_idle_csn", CSn, 1'b1);
        check("rstw_dout", cpu_dout, 8'hFF);
        v = '{rd:1, wr:0, a:11'h155, d:8'h00, scr:0, exp_dout:8'hA5};
        access(v, 0, 1'b1);
        check("rstw_recover_csn", m_csn, 6'b000111);
        release_req();

        // SETUP_CYC=3, STROBE_CYC=1 read on the second instance
        begin
            logic [6:0] c2, w2;
            logic [7:0] d4, d5;
            c2 = '0; w2 = '0; d4 = 8'h00; d5 = 8'h00;
            @(negedge clk);
            cs2 = 1; rd2 = 1; addr = 11'h044;
            for (int k = 1; k <= 7; k++) begin
                @(negedge clk);
                c2[k-1] = ~CSn2;
                w2[k-1] = cpu_wait2;
                if (k == 4) d4 = cpu_dout2;
                if (k == 5) d5 = cpu_dout2;
            end
            check("p2_csn", c2, 7'b0001111);
            check("p2_wait", w2, 7'b0011111);
            check("p2_dout_c4", d4, 8'hFF);
            check("p2_dout_c5", d5, 8'hC3);
            cs2 = 0; rd2 = 0;
            @(negedge clk);
        end

        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish within 200000 time units");
        $fatal(1);
    end

endmodule
